cpu_state_sequencer: RTL and testbench
======================================

Name: cpu_state_sequencer

Overview:
- Main-control state sequencer for the CPU; produces the one-hot phase signals (IF0..MUL4) consumed by the instruction decoder.
- Walks each instruction through fetch, from-operand fetch, to-operand fetch, execute, multiply loop and interrupt entry.
- Branches on decoder flags, memory wait and gated interrupt requests.
- Sits beside the ISR/decoder pair inside the controller.

Parameters:
- MUL_STEPS, 16, number of MUL2_1/MUL2_2 iterations per multiply; legal range 1..31.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- CLR  in  1  synchronous active-high reset.
- f_is_D  in  1  from-operand is register direct; skip FF0-FF2.
- t_is_D  in  1  to-operand is register direct; skip TF0-TF1.
- op_MUL  in  1  instruction is a multiply.
- op_SVC  in  1  instruction is a supervisor call.
- EIT_gate  in  1  external interrupt request, already masked.
- OIT_gate  in  1  other/internal interrupt request, already masked.
- WAIT  in  1  memory not ready; stretches memory states.
- IF0, IF1, FF0, FF1, FF2, TF0, TF1, EX0, EX1, IT0, IT1, IT2, MUL1, MUL2_1, MUL2_2, MUL3, MUL4  out  1 each  one-hot phase outputs.
- MUL_CNT  out  5  multiply iteration index.
- IT_CAUSE  out  2  interrupt cause: 00 none, 01 SVC, 10 EIT, 11 OIT.
- INST_END  out  1  one-cycle pulse on the final cycle of an instruction or interrupt entry.

Behaviour:
- Reset (CLR=1 at an edge): IF0=1; all other phase bits 0; MUL_CNT=0; IT_CAUSE=00; INST_END=0; latched flags cleared. Reset wins over every other input, including mid-multiply and mid-wait.
- Exactly one phase bit is high every cycle after reset; this invariant is asserted in the testbench.
- Flag latch: f_is_D, t_is_D, op_MUL and op_SVC are valid during IF1. They are captured into internal registers on the IF1 exit edge (the edge where WAIT=0). Only the captured copies steer the rest of the instruction.
- Memory states: IF1, FF2, TF1, EX1, IT1, IT2. While WAIT=1 the state holds. WAIT is ignored in every other state.
- Transitions:
  - IF0 -> IF1.
  - IF1 -> FF0 if !f_is_D; else TF0 if !t_is_D; else MUL1 if op_MUL; else EX0. This decision uses the live inputs on the capture edge.
  - FF0 -> FF1 -> FF2.
  - FF2 -> TF0 if !t_is_D; else MUL1/EX0, using the latched flags.
  - TF0 -> TF1 -> MUL1 if op_MUL, else EX0.
  - EX0 -> EX1 -> boundary check.
  - MUL1 -> MUL2_1 and clears MUL_CNT. MUL2_1 -> MUL2_2.
  - MUL2_2 -> MUL3 if MUL_CNT == MUL_STEPS-1; else MUL2_1 with MUL_CNT+1.
  - MUL3 -> MUL4 -> boundary check.
  - IT0 -> IT1 -> IT2 -> IF0.
- Boundary check (exit of EX1 or MUL4):
  - IT0 if latched SVC, EIT_gate or OIT_gate is active; else IF0.
  - Priority is SVC > EIT > OIT. The winning cause is loaded into IT_CAUSE on that edge, held through IT2, and cleared to 00 on entry to IF0.
  - Requests arriving outside the boundary edge are not latched; the source must hold them.
- INST_END=1 during the last cycle of EX1, MUL4 or IT2 only when the state actually advances, i.e. not while WAIT is stretching that cycle.
- MUL_CNT holds its value outside MUL1 through MUL3 and never wraps past MUL_STEPS-1.
- Latency register-direct non-MUL: 4 cycles (IF0, IF1, EX0, EX1).

Optional Feature:
- Macro: CPU_STATE_SEQ_HALT_EN.
- When defined:
  - Adds input HALT and output HALTED.
  - At the boundary check with no interrupt pending and HALT=1, the sequencer enters a HALT state instead of IF0: all phase bits 0, HALTED=1.
  - It leaves to IF0 on the first edge with HALT=0.
  - An interrupt request in HALT leaves to IT0 and sets IT_CAUSE.
  - CLR exits HALT.
  - Gives single-step when HALT is pulsed low for one cycle.
- When undefined: no HALT/HALTED ports and no HALT state; the one-hot invariant holds unconditionally.

Test Plan:
- Reset, then register-direct ADD (f_is_D=1, t_is_D=1, WAIT=0) -> phases IF0, IF1, EX0, EX1, IF0; INST_END high in the EX1 cycle only.
- Memory-operand MOV (f_is_D=0, t_is_D=0), WAIT=1 for 2 cycles in FF2 -> IF0, IF1, FF0, FF1, FF2 x3, TF0, TF1, EX0, EX1; 11 cycles total.
- Multiply with MUL_STEPS=16, register direct -> MUL1, then 16 MUL2_1/MUL2_2 pairs with MUL_CNT 0..15, then MUL3, MUL4; MUL_CNT=15 at MUL3.
- EIT_gate and OIT_gate both 1 at the EX1 exit -> IT0 with IT_CAUSE=10; IT0, IT1, IT2, IF0; IT_CAUSE returns to 00 in IF0.
- op_SVC=1 plus OIT_gate=1 at the boundary -> IT_CAUSE=01.
- CLR asserted in MUL2_2 with MUL_CNT=7 -> next cycle IF0=1, MUL_CNT=0, IT_CAUSE=00.
- With CPU_STATE_SEQ_HALT_EN, HALT=1 at the EX1 exit -> HALTED=1 and all phase bits 0; HALT low for 1 cycle -> exactly one instruction runs, then HALT again.

Source files
------------

// File: rtl/cpu_state_sequencer.sv
// -----------------------------------------------------------------------------
// cpu_state_sequencer
//
// Main-control state sequencer for the CPU. It steps each instruction through
// these phases:
//   - instruction fetch (IF0/IF1)
//   - from-operand fetch (FF0-FF2)
//   - to-operand fetch (TF0/TF1)
//   - execute (EX0/EX1)
//   - a multi-step multiply loop (MUL1..MUL4)
//   - interrupt entry (IT0-IT2)
// Exactly one phase output is high in every cycle. The instruction decoder
// consumes these one-hot phase outputs.
//
// Parameters
//   MUL_STEPS  number of MUL2_1/MUL2_2 iterations per multiply (1..31)
//
// Ports
//   CLK        clock, rising-edge active
//   CLR        synchronous active-high reset (wins over every other input)
//   f_is_D     from-operand is register direct (skip FF0-FF2), valid in IF1
//   t_is_D     to-operand is register direct (skip TF0-TF1), valid in IF1
//   op_MUL     instruction is a multiply, valid in IF1
//   op_SVC     instruction is a supervisor call, valid in IF1
//   EIT_gate   masked external interrupt request (sampled at boundary only)
//   OIT_gate   masked other/internal interrupt request (boundary only)
//   WAIT       memory not ready; stretches IF1, FF2, TF1, EX1, IT1, IT2
//   IF0..MUL4  one-hot phase outputs
//   MUL_CNT    multiply iteration index
//   IT_CAUSE   00 none, 01 SVC, 10 EIT, 11 OIT
//   INST_END   pulse on the final (advancing) cycle of EX1, MUL4 or IT2
//
// Optional build macro CPU_STATE_SEQ_HALT_EN adds these ports:
//   HALT       request to park at the next instruction boundary
//   HALTED     high while parked; in that state every phase output is low
// -----------------------------------------------------------------------------
module cpu_state_sequencer #(
  parameter int MUL_STEPS = 16
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       f_is_D,
  input  logic       t_is_D,
  input  logic       op_MUL,
  input  logic       op_SVC,
  input  logic       EIT_gate,
  input  logic       OIT_gate,
  input  logic       WAIT,
`ifdef CPU_STATE_SEQ_HALT_EN
  input  logic       HALT,
`endif
  output logic       IF0,
  output logic       IF1,
  output logic       FF0,
  output logic       FF1,
  output logic       FF2,
  output logic       TF0,
  output logic       TF1,
  output logic       EX0,
  output logic       EX1,
  output logic       IT0,
  output logic       IT1,
  output logic       IT2,
  output logic       MUL1,
  output logic       MUL2_1,
  output logic       MUL2_2,
  output logic       MUL3,
  output logic       MUL4,
  output logic [4:0] MUL_CNT,
  output logic [1:0] IT_CAUSE,
`ifdef CPU_STATE_SEQ_HALT_EN
  output logic       HALTED,
`endif
  output logic       INST_END
);

  localparam logic [4:0] MUL_LAST = 5'(MUL_STEPS - 1);

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_SVC  = 2'b01;
  localparam logic [1:0] CAUSE_EIT  = 2'b10;
  localparam logic [1:0] CAUSE_OIT  = 2'b11;

  typedef enum logic [4:0] {
    ST_IF0,
    ST_IF1,
    ST_FF0,
    ST_FF1,
    ST_FF2,
    ST_TF0,
    ST_TF1,
    ST_EX0,
    ST_EX1,
    ST_IT0,
    ST_IT1,
    ST_IT2,
    ST_MUL1,
    ST_MUL2_1,
    ST_MUL2_2,
    ST_MUL3,
    ST_MUL4
`ifdef CPU_STATE_SEQ_HALT_EN
    ,
    ST_HALT
`endif
  } state_t;

  state_t     state_reg,   state_next;
  logic [4:0] mul_cnt_reg, mul_cnt_next;
  logic [1:0] cause_reg,   cause_next;

  // Decoder flags captured on the IF1 exit edge. These copies steer the
  // instruction after IF1, so the decoder may change its outputs freely.
  logic t_d_reg,  t_d_next;
  logic mul_reg,  mul_next;
  logic svc_reg,  svc_next;

  logic       inst_end;
  logic [1:0] irq_cause;
  logic       irq_pending;

  // Interrupt arbitration (SVC > EIT > OIT). The gates are live inputs. They
  // are only acted on at an instruction boundary or while parked in HALT, so
  // a source must hold its request until it is taken.
  always_comb begin
    irq_cause = CAUSE_NONE;
    if (svc_reg) begin
      irq_cause = CAUSE_SVC;
    end else if (EIT_gate) begin
      irq_cause = CAUSE_EIT;
    end else if (OIT_gate) begin
      irq_cause = CAUSE_OIT;
    end
    irq_pending = (irq_cause != CAUSE_NONE);
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_reg   <= ST_IF0;
      mul_cnt_reg <= 5'd0;
      cause_reg   <= CAUSE_NONE;
      t_d_reg     <= 1'b0;
      mul_reg     <= 1'b0;
      svc_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      mul_cnt_reg <= mul_cnt_next;
      cause_reg   <= cause_next;
      t_d_reg     <= t_d_next;
      mul_reg     <= mul_next;
      svc_reg     <= svc_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    mul_cnt_next = mul_cnt_reg;
    cause_next   = cause_reg;
    t_d_next     = t_d_reg;
    mul_next     = mul_reg;
    svc_next     = svc_reg;
    inst_end     = 1'b0;

    case (state_reg)
      ST_IF0: state_next = ST_IF1;

      ST_IF1: begin
        if (!WAIT) begin
          t_d_next = t_is_D;
          mul_next = op_MUL;
          svc_next = op_SVC;
          // The captured values do not exist yet on this edge, so branch on
          // the live decoder flags.
          if (!f_is_D) begin
            state_next = ST_FF0;
          end else if (!t_is_D) begin
            state_next = ST_TF0;
          end else if (op_MUL) begin
            state_next = ST_MUL1;
          end else begin
            state_next = ST_EX0;
          end
        end
      end

      ST_FF0: state_next = ST_FF1;
      ST_FF1: state_next = ST_FF2;

      ST_FF2: begin
        if (!WAIT) begin
          if (!t_d_reg) begin
            state_next = ST_TF0;
          end else if (mul_reg) begin
            state_next = ST_MUL1;
          end else begin
            state_next = ST_EX0;
          end
        end
      end

      ST_TF0: state_next = ST_TF1;

      ST_TF1: begin
        if (!WAIT) begin
          state_next = mul_reg ? ST_MUL1 : ST_EX0;
        end
      end

      ST_EX0: state_next = ST_EX1;

      ST_EX1: begin
        if (!WAIT) begin
          inst_end = 1'b1;
          if (irq_pending) begin
            state_next = ST_IT0;
            cause_next = irq_cause;
          end else begin
`ifdef CPU_STATE_SEQ_HALT_EN
            state_next = HALT ? ST_HALT : ST_IF0;
`else
            state_next = ST_IF0;
`endif
            cause_next = CAUSE_NONE;
          end
        end
      end

      ST_MUL1: begin
        state_next   = ST_MUL2_1;
        mul_cnt_next = 5'd0;
      end

      ST_MUL2_1: state_next = ST_MUL2_2;

      ST_MUL2_2: begin
        // Use >= rather than == so the counter can never run past the last
        // step, even if the count is out of range.
        if (mul_cnt_reg >= MUL_LAST) begin
          state_next = ST_MUL3;
        end else begin
          state_next   = ST_MUL2_1;
          mul_cnt_next = mul_cnt_reg + 5'd1;
        end
      end

      ST_MUL3: state_next = ST_MUL4;

      ST_MUL4: begin
        inst_end = 1'b1;
        if (irq_pending) begin
          state_next = ST_IT0;
          cause_next = irq_cause;
        end else begin
`ifdef CPU_STATE_SEQ_HALT_EN
          state_next = HALT ? ST_HALT : ST_IF0;
`else
          state_next = ST_IF0;
`endif
          cause_next = CAUSE_NONE;
        end
      end

      ST_IT0: state_next = ST_IT1;

      ST_IT1: begin
        if (!WAIT) begin
          state_next = ST_IT2;
        end
      end

      ST_IT2: begin
        if (!WAIT) begin
          inst_end   = 1'b1;
          state_next = ST_IF0;
          cause_next = CAUSE_NONE;
        end
      end

`ifdef CPU_STATE_SEQ_HALT_EN
      // Parked between instructions. An interrupt takes priority over
      // resuming, and dropping HALT for one cycle runs a single instruction.
      ST_HALT: begin
        if (irq_pending) begin
          state_next = ST_IT0;
          cause_next = irq_cause;
        end else if (!HALT) begin
          state_next = ST_IF0;
        end
      end
`endif

      default: begin
        state_next = ST_IF0;
        cause_next = CAUSE_NONE;
      end
    endcase
  end

  // One-hot phase decode straight from the state register.
  assign IF0    = (state_reg == ST_IF0);
  assign IF1    = (state_reg == ST_IF1);
  assign FF0    = (state_reg == ST_FF0);
  assign FF1    = (state_reg == ST_FF1);
  assign FF2    = (state_reg == ST_FF2);
  assign TF0    = (state_reg == ST_TF0);
  assign TF1    = (state_reg == ST_TF1);
  assign EX0    = (state_reg == ST_EX0);
  assign EX1    = (state_reg == ST_EX1);
  assign IT0    = (state_reg == ST_IT0);
  assign IT1    = (state_reg == ST_IT1);
  assign IT2    = (state_reg == ST_IT2);
  assign MUL1   = (state_reg == ST_MUL1);
  assign MUL2_1 = (state_reg == ST_MUL2_1);
  assign MUL2_2 = (state_reg == ST_MUL2_2);
  assign MUL3   = (state_reg == ST_MUL3);
  assign MUL4   = (state_reg == ST_MUL4);

`ifdef CPU_STATE_SEQ_HALT_EN
  assign HALTED = (state_reg == ST_HALT);
`endif

  assign MUL_CNT  = mul_cnt_reg;
  assign IT_CAUSE = cause_reg;
  assign INST_END = inst_end;

endmodule

// File: tb/tb_cpu_state_sequencer.sv
module tb_cpu_state_sequencer;

  logic CLK, CLR;
  logic f_is_D, t_is_D, op_MUL, op_SVC, EIT_gate, OIT_gate, WAIT;
  logic IF0, IF1, FF0, FF1, FF2, TF0, TF1, EX0, EX1, IT0, IT1, IT2;
  logic MUL1, MUL2_1, MUL2_2, MUL3, MUL4;
  logic [4:0] MUL_CNT;
  logic [1:0] IT_CAUSE;
  logic INST_END;
`ifdef CPU_STATE_SEQ_HALT_EN
  logic HALT, HALTED;
`endif

  int n_pass = 0;
  int n_total = 0;
  bit mon_en = 0;

  localparam logic [16:0] P_NONE = 17'h00000;
  localparam logic [16:0] P_IF0  = 17'h10000;
  localparam logic [16:0] P_IF1  = 17'h08000;
  localparam logic [16:0] P_FF0  = 17'h04000;
  localparam logic [16:0] P_FF1  = 17'h02000;
  localparam logic [16:0] P_FF2  = 17'h01000;
  localparam logic [16:0] P_TF0  = 17'h00800;
  localparam logic [16:0] P_TF1  = 17'h00400;
  localparam logic [16:0] P_EX0  = 17'h00200;
  localparam logic [16:0] P_EX1  = 17'h00100;
  localparam logic [16:0] P_IT0  = 17'h00080;
  localparam logic [16:0] P_IT1  = 17'h00040;
  localparam logic [16:0] P_IT2  = 17'h00020;
  localparam logic [16:0] P_MUL1 = 17'h00010;
  localparam logic [16:0] P_M21  = 17'h00008;
  localparam logic [16:0] P_M22  = 17'h00004;
  localparam logic [16:0] P_MUL3 = 17'h00002;
  localparam logic [16:0] P_MUL4 = 17'h00001;

  logic [16:0] phase;
  assign phase = {IF0, IF1, FF0, FF1, FF2, TF0, TF1, EX0, EX1, IT0, IT1, IT2,
                  MUL1, MUL2_1, MUL2_2, MUL3, MUL4};

  cpu_state_sequencer #(.MUL_STEPS(16)) dut (
    .CLK(CLK), .CLR(CLR),
    .f_is_D(f_is_D), .t_is_D(t_is_D), .op_MUL(op_MUL), .op_SVC(op_SVC),
    .EIT_gate(EIT_gate), .OIT_gate(OIT_gate), .WAIT(WAIT),
`ifdef CPU_STATE_SEQ_HALT_EN
    .HALT(HALT),
`endif
    .IF0(IF0), .IF1(IF1), .FF0(FF0), .FF1(FF1), .FF2(FF2),
    .TF0(TF0), .TF1(TF1), .EX0(EX0), .EX1(EX1),
    .IT0(IT0), .IT1(IT1), .IT2(IT2),
    .MUL1(MUL1), .MUL2_1(MUL2_1), .MUL2_2(MUL2_2), .MUL3(MUL3), .MUL4(MUL4),
    .MUL_CNT(MUL_CNT), .IT_CAUSE(IT_CAUSE),
`ifdef CPU_STATE_SEQ_HALT_EN
    .HALTED(HALTED),
`endif
    .INST_END(INST_END)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One-hot invariant, checked on every falling edge once out of reset.
  always @(negedge CLK) begin
    if (mon_en) begin
      bit ok;
`ifdef CPU_STATE_SEQ_HALT_EN
      ok = $onehot(phase) || (HALTED && phase == P_NONE);
`else
      ok = $onehot(phase);
`endif
      n_total++;
      if (!ok) $display("FAIL onehot_invariant phase=%b required exactly one bit set", phase);
      else n_pass++;
    end
  end

  task automatic test_reset();
    CLR = 1; WAIT = 1; EIT_gate = 1; OIT_gate = 1; op_MUL = 1; op_SVC = 1;
    f_is_D = 0; t_is_D = 0;
`ifdef CPU_STATE_SEQ_HALT_EN
    HALT = 0;
`endif
    tick(); tick();
    CLR = 0; WAIT = 0; EIT_gate = 0; OIT_gate = 0; op_MUL = 0; op_SVC = 0;
    #1;
    n_total++;
    if (phase !== P_IF0) $display("FAIL reset_phase got %b want %b", phase, P_IF0); else n_pass++;
    n_total++;
    if (MUL_CNT !== 5'd0) $display("FAIL reset_mul_cnt got %0d want 0", MUL_CNT); else n_pass++;
    n_total++;
    if (IT_CAUSE !== 2'b00) $display("FAIL reset_it_cause got %b want 00", IT_CAUSE); else n_pass++;
    n_total++;
    if (INST_END !== 1'b0) $display("FAIL reset_inst_end got %b want 0", INST_END); else n_pass++;
    mon_en = 1;
    $display("reset: phase=%b mul_cnt=%0d cause=%b", phase, MUL_CNT, IT_CAUSE);
  endtask

  task automatic test_add();
    logic [16:0] eph [5];
    logic        een [5];
    eph = '{P_IF0, P_IF1, P_EX0, P_EX1, P_IF0};
    een = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    f_is_D = 1; t_is_D = 1; op_MUL = 0; op_SVC = 0; WAIT = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_total++;
      if (phase !== eph[i]) $display("FAIL add_phase[%0d] got %b want %b", i, phase, eph[i]); else n_pass++;
      n_total++;
      if (INST_END !== een[i]) $display("FAIL add_inst_end[%0d] got %b want %b", i, INST_END, een[i]); else n_pass++;
      if (i < 4) tick();
    end
    $display("add: register-direct instruction done");
  endtask

  task automatic test_mov_wait();
    logic [16:0] eph [12];
    logic        een [12];
    logic        ewt [12];
    eph = '{P_IF0, P_IF1, P_FF0, P_FF1, P_FF2, P_FF2, P_FF2, P_TF0, P_TF1, P_EX0, P_EX1, P_IF0};
    een = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    // WAIT held in FF2 for two cycles, and also raised in TF0 where it is ignored.
    ewt = '{0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0};
    f_is_D = 0; t_is_D = 0; op_MUL = 0; op_SVC = 0;
    for (int i = 0; i < 12; i++) begin
      // After capture the live flags change; only the latched copies may steer.
      if (i == 2) begin f_is_D = 1; t_is_D = 1; op_MUL = 1; end
      WAIT = ewt[i];
      #1;
      n_total++;
      if (phase !== eph[i]) $display("FAIL mov_phase[%0d] got %b want %b", i, phase, eph[i]); else n_pass++;
      n_total++;
      if (INST_END !== een[i]) $display("FAIL mov_inst_end[%0d] got %b want %b", i, INST_END, een[i]); else n_pass++;
      if (i < 11) tick();
    end
    WAIT = 0; op_MUL = 0;
    $display("mov: memory operands with FF2 wait done");
  endtask

  task automatic test_mul();
    f_is_D = 1; t_is_D = 1; op_MUL = 1; op_SVC = 0; WAIT = 0;
    #1;
    n_total++;
    if (phase !== P_IF0) $display("FAIL mul_start got %b want %b", phase, P_IF0); else n_pass++;
    tick(); tick();
    op_MUL = 0;
    #1;
    n_total++;
    if (phase !== P_MUL1) $display("FAIL mul_mul1 got %b want %b", phase, P_MUL1); else n_pass++;
    tick();
    for (int k = 0; k < 16; k++) begin
      n_total++;
      if (phase !== P_M21 || MUL_CNT !== 5'(k))
        $display("FAIL mul_m21[%0d] got phase=%b cnt=%0d want phase=%b cnt=%0d", k, phase, MUL_CNT, P_M21, k);
      else n_pass++;
      tick();
      n_total++;
      if (phase !== P_M22 || MUL_CNT !== 5'(k))
        $display("FAIL mul_m22[%0d] got phase=%b cnt=%0d want phase=%b cnt=%0d", k, phase, MUL_CNT, P_M22, k);
      else n_pass++;
      tick();
    end
    n_total++;
    if (phase !== P_MUL3 || MUL_CNT !== 5'd15)
      $display("FAIL mul_mul3 got phase=%b cnt=%0d want phase=%b cnt=15", phase, MUL_CNT, P_MUL3);
    else n_pass++;
    tick();
    n_total++;
    if (phase !== P_MUL4 || INST_END !== 1'b1)
      $display("FAIL mul_mul4 got phase=%b end=%b want phase=%b end=1", phase, INST_END, P_MUL4);
    else n_pass++;
    tick();
    n_total++;
    if (phase !== P_IF0 || MUL_CNT !== 5'd15 || INST_END !== 1'b0)
      $display("FAIL mul_done got phase=%b cnt=%0d end=%b want phase=%b cnt=15 end=0", phase, MUL_CNT, INST_END, P_IF0);
    else n_pass++;
    $display("mul: 16-step multiply done");
  endtask

  task automatic test_irq(input bit use_svc);
    logic [16:0] eph [9];
    logic [1:0]  eca [9];
    logic        een [9];
    logic        ewt [9];
    logic [1:0]  want;
    want = use_svc ? 2'b01 : 2'b10;
    // IT2 is stretched once by WAIT, so INST_END is held off for that cycle.
    eph = '{P_IF0, P_IF1, P_EX0, P_EX1, P_IT0, P_IT1, P_IT2, P_IT2, P_IF0};
    eca = '{2'b00, 2'b00, 2'b00, 2'b00, want, want, want, want, 2'b00};
    een = '{0, 0, 0, 1, 0, 0, 0, 1, 0};
    ewt = '{0, 0, 0, 0, 0, 0, 1, 0, 0};
    f_is_D = 1; t_is_D = 1; op_MUL = 0; op_SVC = use_svc;
    EIT_gate = !use_svc; OIT_gate = 1;
    for (int i = 0; i < 9; i++) begin
      if (i == 2) op_SVC = 0;
      if (i == 4) begin EIT_gate = 0; OIT_gate = 0; end
      WAIT = ewt[i];
      #1;
      n_total++;
      if (phase !== eph[i]) $display("FAIL irq%0d_phase[%0d] got %b want %b", use_svc, i, phase, eph[i]); else n_pass++;
      n_total++;
      if (IT_CAUSE !== eca[i]) $display("FAIL irq%0d_cause[%0d] got %b want %b", use_svc, i, IT_CAUSE, eca[i]); else n_pass++;
      n_total++;
      if (INST_END !== een[i]) $display("FAIL irq%0d_inst_end[%0d] got %b want %b", use_svc, i, INST_END, een[i]); else n_pass++;
      if (i < 8) tick();
    end
    WAIT = 0;
    $display("irq: %s entry done", use_svc ? "SVC over OIT" : "EIT over OIT");
  endtask

  task automatic test_no_latch();
    // A request pulsed during EX0 and dropped before the boundary is not taken.
    f_is_D = 1; t_is_D = 1; op_MUL = 0; op_SVC = 0; WAIT = 0;
    tick(); tick();
    EIT_gate = 1;
    tick();
    EIT_gate = 0;
    tick();
    n_total++;
    if (phase !== P_IF0 || IT_CAUSE !== 2'b00)
      $display("FAIL no_latch got phase=%b cause=%b want phase=%b cause=00", phase, IT_CAUSE, P_IF0);
    else n_pass++;
    $display("no_latch: transient request ignored");
  endtask

  task automatic test_clr_mid_mul();
    f_is_D = 1; t_is_D = 1; op_MUL = 1; op_SVC = 0; WAIT = 0;
    repeat (18) tick();
    n_total++;
    if (phase !== P_M22 || MUL_CNT !== 5'd7)
      $display("FAIL clr_pre got phase=%b cnt=%0d want phase=%b cnt=7", phase, MUL_CNT, P_M22);
    else n_pass++;
    CLR = 1; WAIT = 1; EIT_gate = 1;
    tick();
    CLR = 0; WAIT = 0; EIT_gate = 0; op_MUL = 0;
    #1;
    n_total++;
    if (phase !== P_IF0 || MUL_CNT !== 5'd0 || IT_CAUSE !== 2'b00 || INST_END !== 1'b0)
      $display("FAIL clr_post got phase=%b cnt=%0d cause=%b end=%b want phase=%b cnt=0 cause=00 end=0",
               phase, MUL_CNT, IT_CAUSE, INST_END, P_IF0);
    else n_pass++;
    tick(); tick();
    n_total++;
    if (phase !== P_EX0) $display("FAIL clr_resume got %b want %b", phase, P_EX0); else n_pass++;
    tick(); tick();
    $display("clr: reset in MUL2_2 done");
  endtask

`ifdef CPU_STATE_SEQ_HALT_EN
  task automatic test_halt();
    logic [16:0] eph [15];
    logic        ehl [15];
    logic [1:0]  eca [15];
    eph = '{P_IF0, P_IF1, P_EX0, P_EX1, P_NONE, P_NONE, P_IF0, P_IF1, P_EX0, P_EX1,
            P_NONE, P_IT0, P_IT1, P_IT2, P_IF0};
    ehl = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    eca = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 2, 2, 0};
    f_is_D = 1; t_is_D = 1; op_MUL = 0; op_SVC = 0; WAIT = 0; HALT = 1;
    for (int i = 0; i < 15; i++) begin
      if (i == 5) HALT = 0;
      if (i == 6) HALT = 1;
      if (i == 10) EIT_gate = 1;
      if (i == 11) EIT_gate = 0;
      #1;
      n_total++;
      if (phase !== eph[i] || HALTED !== ehl[i] || IT_CAUSE !== eca[i])
        $display("FAIL halt[%0d] got phase=%b halted=%b cause=%b want phase=%b halted=%b cause=%b",
                 i, phase, HALTED, IT_CAUSE, eph[i], ehl[i], eca[i]);
      else n_pass++;
      if (i < 14) tick();
    end
    HALT = 0;
    $display("halt: single-step and interrupt wake done");
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_mov_wait();
    test_mul();
    test_irq(1'b0);
    test_irq(1'b1);
    test_no_latch();
    test_clr_mid_mul();
`ifdef CPU_STATE_SEQ_HALT_EN
    test_halt();
`endif
    @(posedge CLK);
    mon_en = 0;
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
